text_buffer_ctrl: RTL and testbench

TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

---
 rtl/text_buffer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_text_buffer_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl.sv
// Text buffer controller: turns decoded letters, backspace and clear commands into character-RAM writes and tracks the cursor.
// Optional feature: define TEXT_WRAP_EN to wrap the cursor from the last cell back to cell 0 instead of stopping when full.
module text_buffer_ctrl #(
    parameter int COLS     = 50,
    parameter int ROWS     = 4,
    parameter int ADDR_W   = 8,
    parameter int CHAR_W   = 8,
    parameter int X_ORIGIN = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              letter_valid,
    input  logic [7:0]        letter,
    output logic              letter_ready,
    input  logic              cmd_clear,
    input  logic              cmd_backspace,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        cursor_col,
    output logic [3:0]        cursor_row,
    output logic [11:0]       cursor_x,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full
);

    localparam int                N         = ROWS * COLS;
    localparam logic [ADDR_W:0]   N_CNT     = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
`ifdef TEXT_WRAP_EN
    localparam logic [3:0]        LAST_ROW  = 4'(ROWS - 1);
`endif
    localparam logic [7:0]        SPACE     = 8'hFF;
    localparam logic [11:0]       X_RESET   = 12'(X_ORIGIN);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        BKSP,
        CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [7:0]          wr_data_d;
    logic [7:0]          col_d, adv_col, ret_col;
    logic [3:0]          row_d, adv_row, ret_row;
    logic [ADDR_W:0]     count_d;
    logic                busy_d;
    logic                full_d;
    logic [11:0]         cursor_x_d;
    logic [ADDR_W-1:0]   cursor_addr, ret_addr;

    // Commands pre-empt letters in the same cycle, so a letter is only offered acceptance on a quiet IDLE cycle.
    assign letter_ready = rst_n && (state_q == IDLE) && !full && !cmd_clear && !cmd_backspace;

    // Neighbouring cells of the cursor: one step forward (write) and one step back (backspace).
    always_comb begin
        adv_col = cursor_col + 8'd1;
        adv_row = cursor_row;
        if (cursor_col == LAST_COL) begin
            adv_col = '0;
            adv_row = cursor_row + 4'd1;
`ifdef TEXT_WRAP_EN
            if (cursor_row == LAST_ROW) adv_row = '0;
`endif
        end

        ret_col = cursor_col - 8'd1;
        ret_row = cursor_row;
        if (cursor_col == '0) begin
            ret_col = LAST_COL;
            ret_row = cursor_row - 4'd1;
`ifdef TEXT_WRAP_EN
            if (cursor_row == '0) ret_row = LAST_ROW;
`endif
        end
    end

    assign cursor_addr = ADDR_W'(int'(cursor_row) * COLS + int'(cursor_col));
    assign ret_addr    = ADDR_W'(int'(ret_row) * COLS + int'(ret_col));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        col_d     = cursor_col;
        row_d     = cursor_row;
        count_d   = count;
        busy_d    = busy;

        case (state_q)
            IDLE: begin
                if (cmd_clear) begin
                    state_d   = CLEAR;
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = SPACE;
                end else if (cmd_backspace) begin
                    if (count != '0) begin
                        state_d   = BKSP;
                        col_d     = ret_col;
                        row_d     = ret_row;
                        count_d   = count - CNT_ONE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ret_addr;
                        wr_data_d = SPACE;
                    end
                end else if (letter_valid && letter_ready) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cursor_addr;
                    wr_data_d = letter;
                    col_d     = adv_col;
                    row_d     = adv_row;
                    count_d   = (count == N_CNT) ? count : count + CNT_ONE;
                end
            end
            WRITE, BKSP: state_d = IDLE;
            CLEAR: begin
                if (wr_addr == LAST_ADDR) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    count_d = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr + ADDR_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TEXT_WRAP_EN
    assign full_d = 1'b0;
`else
    assign full_d = (count_d == N_CNT);
`endif

    assign cursor_x_d = 12'(X_ORIGIN + int'(col_d) * CHAR_W);

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            cursor_x   <= X_RESET;
            count      <= '0;
            busy       <= 1'b0;
            full       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            cursor_col <= col_d;
            cursor_row <= row_d;
            cursor_x   <= cursor_x_d;
            count      <= count_d;
            busy       <= busy_d;
            full       <= full_d;
        end
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl: write, wrap to next row, backspace, clear sweep, fill limit and reset abort.
module tb_text_buffer_ctrl;

    localparam int COLS   = 50;
    localparam int ROWS   = 4;
    localparam int ADDR_W = 8;
    localparam int N      = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              letter_valid;
    logic [7:0]        letter;
    logic              letter_ready;
    logic              cmd_clear;
    logic              cmd_backspace;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        cursor_col;
    logic [3:0]        cursor_row;
    logic [11:0]       cursor_x;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              full;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    logic       last_wen;
    logic [7:0] last_addr;
    logic [7:0] last_data;

    text_buffer_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CHAR_W(8), .X_ORIGIN(200)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .letter_valid(letter_valid), .letter(letter), .letter_ready(letter_ready),
        .cmd_clear(cmd_clear), .cmd_backspace(cmd_backspace),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_x(cursor_x),
        .count(count), .busy(busy), .full(full)
    );

    always #5 clk = ~clk;

    // Counts RAM write strobes as the RAM would see them at the clock edge.
    always @(posedge clk) if (wr_en === 1'b1) n_writes++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        letter_valid  = 1'b0;
        letter        = 8'h00;
        cmd_clear     = 1'b0;
        cmd_backspace = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Offers one letter, waits (bounded) for acceptance, captures the write cycle, returns to IDLE.
    task automatic put(input logic [7:0] ch);
        int waited;
        letter_valid = 1'b1;
        letter       = ch;
        #1;
        waited = 0;
        while (letter_ready !== 1'b1 && waited < 500) begin
            tick();
            waited++;
        end
        if (waited >= 500) check("put_ready_timeout", 32'(letter_ready), 32'd1);
        tick();
        letter_valid = 1'b0;
        last_wen  = wr_en;
        last_addr = 8'(wr_addr);
        last_data = wr_data;
        tick();
    endtask

    task automatic bksp();
        cmd_backspace = 1'b1;
        tick();
        cmd_backspace = 1'b0;
        last_wen  = wr_en;
        last_addr = 8'(wr_addr);
        last_data = wr_data;
        tick();
    endtask

    initial begin
        int nw;
        int sweep_bad;

        // Reset state, and ready gated by reset even with a letter offered.
        do_reset();
        rst_n        = 1'b0;
        letter_valid = 1'b1;
        #1;
        check("ready_in_reset", 32'(letter_ready), 32'd0);
        letter_valid = 1'b0;
        rst_n        = 1'b1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_cursor", {cursor_row, cursor_col}, 32'd0);
        check("rst_busy_full", {busy, full}, 32'd0);

        // First letter: ready, then one write cycle at address 0.
        nw = n_writes;
        letter_valid = 1'b1;
        letter       = 8'h41;
        #1;
        check("first_ready", 32'(letter_ready), 32'd1);
        tick();
        letter_valid = 1'b0;
        check("first_wr_en", 32'(wr_en), 32'd1);
        check("first_wr_addr", 32'(wr_addr), 32'd0);
        check("first_wr_data", 32'(wr_data), 32'h41);
        check("first_cursor_x", 32'(cursor_x), 32'd208);
        check("first_count", 32'(count), 32'd1);
        tick();
        check("first_idle_wr_en", 32'(wr_en), 32'd0);
        check("first_one_write", 32'(n_writes - nw), 32'd1);

        // Fill row 0, then the 51st letter lands at the start of row 1.
        for (int i = 1; i < COLS; i++) put(8'h61 + 8'(i % 26));
        check("row0_last_addr", 32'(last_addr), 32'd49);
        check("row_wrap_cursor", {cursor_row, cursor_col}, {4'd1, 8'd0});
        check("row_wrap_x", 32'(cursor_x), 32'd200);
        put(8'h5A);
        check("l51_addr", 32'(last_addr), 32'd50);
        check("l51_data", 32'(last_data), 32'h5A);
        check("l51_cursor", {cursor_row, cursor_col}, {4'd1, 8'd1});
        check("l51_count", 32'(count), 32'd51);

        // Backspace across the row boundary.
        bksp();
        check("bs_row1_addr", 32'(last_addr), 32'd50);
        bksp();
        check("bs_cross_addr", {last_wen, last_addr, last_data}, {1'b1, 8'd49, 8'hFF});
        check("bs_cross_cursor", {cursor_row, cursor_col}, {4'd0, 8'd49});
        check("bs_cross_x", 32'(cursor_x), 32'd592);

        // Backspace from count 3, then down to empty, then ignored at 0.
        do_reset();
        put(8'h31);
        put(8'h32);
        put(8'h33);
        letter_valid  = 1'b1;
        cmd_backspace = 1'b1;
        #1;
        check("bs_blocks_ready", 32'(letter_ready), 32'd0);
        tick();
        cmd_backspace = 1'b0;
        letter_valid  = 1'b0;
        check("bs3_write", {wr_en, 8'(wr_addr), wr_data}, {1'b1, 8'd2, 8'hFF});
        check("bs3_count", 32'(count), 32'd2);
        tick();
        bksp();
        bksp();
        check("bs_to_zero_count", 32'(count), 32'd0);
        nw = n_writes;
        bksp();
        check("bs_empty_no_wr", 32'(last_wen), 32'd0);
        tick();
        check("bs_empty_writes", 32'(n_writes - nw), 32'd0);
        check("bs_empty_count", 32'(count), 32'd0);

        // Clear together with a pending letter: full sweep, then the letter at address 0.
        put(8'h44);
        cmd_clear    = 1'b1;
        letter_valid = 1'b1;
        letter       = 8'h5A;
        #1;
        check("clr_blocks_ready", 32'(letter_ready), 32'd0);
        tick();
        cmd_clear = 1'b0;
        sweep_bad = 0;
        for (int i = 0; i < N; i++) begin
            if (!(wr_en === 1'b1 && busy === 1'b1 && int'(wr_addr) == i && wr_data === 8'hFF
                  && letter_ready === 1'b0)) sweep_bad++;
            cmd_backspace = (i == 10);
            tick();
        end
        cmd_backspace = 1'b0;
        check("clr_sweep_bad_cycles", 32'(sweep_bad), 32'd0);
        check("clr_done", {busy, wr_en, 23'd0, count}, 32'd0);
        check("clr_cursor", {cursor_row, cursor_col}, 32'd0);
        check("clr_ready_after", 32'(letter_ready), 32'd1);
        tick();
        letter_valid = 1'b0;
        check("clr_letter_write", {wr_en, 8'(wr_addr), wr_data}, {1'b1, 8'd0, 8'h5A});
        tick();

        // Fill every cell.
        do_reset();
        for (int i = 0; i < N; i++) put(8'h30 + 8'(i % 10));
        check("fill_last_addr", 32'(last_addr), 32'd199);
        check("fill_count", 32'(count), 32'd200);
`ifdef TEXT_WRAP_EN
        check("wrap_full", 32'(full), 32'd0);
        check("wrap_cursor", {cursor_row, cursor_col}, 32'd0);
        put(8'h58);
        check("wrap_201_addr", 32'(last_addr), 32'd0);
        check("wrap_count_sat", 32'(count), 32'd200);
`else
        check("fill_full", 32'(full), 32'd1);
        nw = n_writes;
        letter_valid = 1'b1;
        letter       = 8'h58;
        #1;
        check("full_not_ready", 32'(letter_ready), 32'd0);
        repeat (3) tick();
        check("full_no_writes", 32'(n_writes - nw), 32'd0);
        cmd_backspace = 1'b1;
        tick();
        cmd_backspace = 1'b0;
        check("full_bs_write", {wr_en, 8'(wr_addr), wr_data}, {1'b1, 8'd199, 8'hFF});
        check("full_bs_count", {full, 23'd0, count}, 32'd199);
        tick();
        check("full_held_ready", 32'(letter_ready), 32'd1);
        tick();
        letter_valid = 1'b0;
        check("full_held_write", {wr_en, 8'(wr_addr), wr_data}, {1'b1, 8'd199, 8'h58});
        check("full_again", 32'(full), 32'd1);
        tick();
`endif

        // Reset in the middle of a clear sweep.
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        repeat (49) tick();
        check("abort_pre_busy", {busy, 8'(wr_addr)}, {1'b1, 8'd49});
        rst_n = 1'b0;
        tick();
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_busy_count", {busy, 23'd0, count}, 32'd0);
        check("abort_addr", 32'(wr_addr), 32'd0);
        nw = n_writes;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_writes", 32'(n_writes - nw), 32'd0);
        check("abort_stays_idle", {busy, wr_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
